// File: rtl/operand2_sequencer.sv
// Multi-cycle operand-2 sequencer: reads Rm/Rs over one RF port, drives the barrel shifter, registers the result.
// Optional macro OPERAND2_SEQ_SHIFT32_EN adds the register-shift amount >= 32 overrides.
module operand2_sequencer #(
    parameter int RF_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          instr,
    input  logic [3:0]           flags_in,
    output logic [RF_ADDR_W-1:0] rf_addr,
    input  logic [31:0]          rf_data,
    output logic                 sh_vimm,
    output logic                 sh_bimm,
    output logic [1:0]           sh_type,
    output logic [7:0]           sh_valimm,
    output logic [31:0]          sh_valreg,
    output logic [31:0]          sh_byimm,
    output logic [7:0]           sh_byreg,
    output logic [3:0]           sh_flags,
    input  logic [31:0]          sh_data,
    input  logic [3:0]           sh_flagsout,
    output logic [31:0]          op2,
    output logic [3:0]           flags_out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [2:0] {IDLE, RD_RM, RD_RS, EXEC, DONE} state_e;

    localparam logic [1:0] T_LSR = 2'd1;
    localparam logic [1:0] T_ASR = 2'd2;
    localparam logic [1:0] T_ROR = 2'd3;

    state_e      state_q, state_d;
    logic [12:0] instr_q, instr_d;   // {I, instr[11:0]}
    logic [3:0]  flags_q, flags_d;
    logic [31:0] rm_q, rm_d;
    logic [31:0] op2_q, op2_d;
    logic [3:0]  flags_out_q, flags_out_d;

    logic        accept;
    logic        is_imm, by_rs;
    logic [1:0]  sh_kind;
    logic [4:0]  amount;
    logic [7:0]  imm8;
    logic [3:0]  rot, rm_idx, rs_idx;
    logic [31:0] rm_val;
    logic [7:0]  rs_byte;
    logic [31:0] res_op2;
    logic [3:0]  res_flags;

    assign is_imm  = instr_q[12];
    assign by_rs   = instr_q[4];
    assign sh_kind = instr_q[6:5];
    assign amount  = instr_q[11:7];
    assign imm8    = instr_q[7:0];
    assign rot     = instr_q[11:8];
    assign rm_idx  = instr_q[3:0];
    assign rs_idx  = instr_q[11:8];
    // Rm is latched only when an Rs read follows; otherwise it is still on the read port in EXEC.
    assign rm_val  = by_rs ? rm_q : rf_data;
    assign rs_byte = rf_data[7:0];
    assign accept  = (state_q == IDLE) && req_valid;

    // NOTE: state and datapath flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            flags_q     <= '0;
            rm_q        <= '0;
            op2_q       <= '0;
            flags_out_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            flags_q     <= flags_d;
            rm_q        <= rm_d;
            op2_q       <= op2_d;
            flags_out_q <= flags_out_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = instr[25] ? EXEC : RD_RM;
            RD_RM:   state_d = by_rs ? RD_RS : EXEC;
            RD_RS:   state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        out_valid = (state_q == DONE);
        rf_addr   = '0;
        sh_vimm   = 1'b0;
        sh_bimm   = 1'b0;
        sh_type   = 2'd0;
        sh_valimm = '0;
        sh_valreg = '0;
        sh_byimm  = '0;
        sh_byreg  = '0;
        sh_flags  = '0;
        if (state_q == RD_RM) rf_addr = RF_ADDR_W'(rm_idx);
        if (state_q == RD_RS) rf_addr = RF_ADDR_W'(rs_idx);
        if (state_q == EXEC) begin
            sh_flags = flags_q;
            if (is_imm) begin
                sh_vimm   = 1'b1;
                sh_bimm   = 1'b1;
                sh_type   = T_ROR;
                sh_valimm = imm8;
                sh_byimm  = {27'd0, rot, 1'b0};
            end else begin
                sh_type   = sh_kind;
                sh_valreg = rm_val;
                if (!by_rs) begin
                    sh_bimm  = 1'b1;
                    sh_byimm = (amount == 5'd0 && (sh_kind == T_LSR || sh_kind == T_ASR))
                             ? 32'd32 : {27'd0, amount};
                end else begin
                    sh_byreg = (sh_kind == T_ROR) ? {3'd0, rf_data[4:0]} : rs_byte;
                end
            end
        end
    end

    // Special-case encodings the shifter does not resolve on its own.
    always_comb begin
        res_op2   = sh_data;
        res_flags = sh_flagsout;
        if (is_imm) begin
            if (rot == 4'd0) begin
                res_op2   = {24'd0, imm8};
                res_flags = flags_q;
            end
        end else if (by_rs) begin
            if (rs_byte == 8'd0) begin
                res_op2   = rm_val;
                res_flags = flags_q;
            end else if (sh_kind == T_ROR && rf_data[4:0] == 5'd0) begin
                res_op2   = rm_val;
                res_flags = {flags_q[3:2], rm_val[31], flags_q[0]};
            end
`ifdef OPERAND2_SEQ_SHIFT32_EN
            else if (sh_kind != T_ROR && rs_byte >= 8'd32) begin
                if (sh_kind == T_ASR) begin
                    res_op2   = {32{rm_val[31]}};
                    res_flags = {flags_q[3:2], rm_val[31], flags_q[0]};
                end else begin
                    res_op2   = '0;
                    res_flags = {flags_q[3:2], 1'b0, flags_q[0]};
                    if (rs_byte == 8'd32)
                        res_flags[1] = (sh_kind == T_LSR) ? rm_val[31] : rm_val[0];
                end
            end
`endif
        end
    end

    always_comb begin
        instr_d     = accept ? {instr[25], instr[11:0]} : instr_q;
        flags_d     = accept ? flags_in : flags_q;
        rm_d        = (state_q == RD_RS) ? rf_data : rm_q;
        op2_d       = (state_q == EXEC) ? res_op2 : op2_q;
        flags_out_d = (state_q == EXEC) ? res_flags : flags_out_q;
    end

    assign op2       = op2_q;
    assign flags_out = flags_out_q;

endmodule

// File: doc/operand2_sequencer.md
# operand2_sequencer

Multi-cycle controller for the data-processing operand-2 path: accepts an instruction word plus NZCV flags, reads Rm and Rs through the single register-file read port, and drives the combinational barrel shifter's control and data inputs. It also fixes ARM special-case encodings that the shifter does not handle, registers the shifted operand and updated flags, and hands them to the ALU stage over a valid/ready handshake.

## Interface
- `RF_ADDR_W`, default 4: register-file address width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: instruction offered.
- `req_ready` out 1: sequencer can accept; high only in IDLE.
- `instr` in 32: instruction word; uses bits [25] and [11:0].
- `flags_in` in 4: NZCV, sampled at accept.
- `rf_addr` out RF_ADDR_W: register read address.
- `rf_data` in 32: read data, valid one cycle after `rf_addr` (synchronous read).
- `sh_vimm`, `sh_bimm` out 1 each: shifter value/amount source selects.
- `sh_type` out 2: LSL=0, LSR=1, ASR=2, ROR=3.
- `sh_valimm` out 8; `sh_valreg` out 32; `sh_byimm` out 32; `sh_byreg` out 8; `sh_flags` out 4: shifter inputs.
- `sh_data` in 32; `sh_flagsout` in 4: shifter outputs.
- `op2` out 32: registered operand-2 result.
- `flags_out` out 4: registered NZCV, only C may differ from the sampled flags.
- `out_valid` out 1; `out_ready` in 1: result handshake.

## Operation
- Decode at accept. I=`instr[25]`. Immediate form: imm8=`[7:0]`, rot=`[11:8]`. Register form: Rm=`[3:0]`, type=`[6:5]`, bit4=0 gives amount=`[11:7]`, bit4=1 gives Rs=`[11:8]`.
- FSM states: IDLE, RD_RM, RD_RS, EXEC, DONE.
  - IDLE to EXEC when an immediate form is accepted.
  - IDLE to RD_RM when a register form is accepted.
  - RD_RM to RD_RS for a register shift, otherwise RD_RM to EXEC.
  - RD_RS to EXEC.
  - EXEC to DONE.
  - DONE to IDLE on `out_ready`.
- RD_RM drives `rf_addr`=Rm. RD_RS drives `rf_addr`=Rs and latches `rf_data` (Rm) into an internal register. EXEC takes Rm from the latch, or from `rf_data` when there is no RD_RS. Rs comes from `rf_data` in EXEC.
- EXEC shifter drive; `sh_flags` is always the sampled flags:
  - Immediate: vimm=1, bimm=1, type=ROR, valimm=imm8, byimm=2*rot. If rot=0: op2=imm8 and C is unchanged (shifter output ignored).
  - Register, shift by immediate: vimm=0, bimm=1. LSR/ASR with amount 0 gives byimm=32. ROR with amount 0 gives byimm=0 (shifter performs RRX). Otherwise byimm=amount.
  - Register, shift by Rs: vimm=0, bimm=0.
    - If Rs[7:0]=0: op2=Rm, C unchanged, override applied.
    - For ROR with Rs[7:0]≠0 and Rs[4:0]=0: op2=Rm, C=Rm[31].
    - For ROR otherwise: byreg={3'b0,Rs[4:0]}.
    - LSL/LSR/ASR: byreg=Rs[7:0].
- `op2` and `flags_out` are captured at the EXEC to DONE edge and held stable while DONE is waiting on `out_ready`.
- In non-EXEC states the shifter inputs are held at 0, and `rf_addr` is 0 outside RD_RM and RD_RS.

## Timing
- E0 is the accept edge (`req_valid && req_ready`). `out_valid` rises after:
  - E1 for immediate forms;
  - E2 for register shift-by-immediate;
  - E3 for register shift-by-Rs.
- `out_valid` is high exactly in DONE. The transfer happens on the edge where `out_valid && out_ready`. The next accept occurs no earlier than the following edge, so throughput is at most one operand per latency+1 cycles.
- `req_ready` is high only in IDLE, so simultaneous completion and new request in DONE does not accept.
- Reset values: state IDLE, `req_ready`=1, `out_valid`=0, `op2`=0, `flags_out`=0, `rf_addr`=0, all `sh_*` outputs 0.
- Reset asserted mid-operation drops the operation asynchronously; no partial result is emitted.
- `req_valid` and `instr` are ignored outside IDLE.

## Configuration
- `OPERAND2_SEQ_SHIFT32_EN` defined: register shift-by-Rs with Rs[7:0]≥32 is overridden in EXEC:
  - LSL/LSR with amount exactly 32: op2=0, C=Rm[0] for LSL, C=Rm[31] for LSR.
  - LSL/LSR with amount >32: op2=0, C=0.
  - ASR ≥32: op2 = 32 copies of Rm[31], C=Rm[31].
- Undefined: these amounts pass straight to the shifter, and `op2`/`flags_out` equal `sh_data`/`sh_flagsout`.

## Test plan
- Immediate imm8=0xFF, rot=1, flags=0x0: `op2`=0xC000003F, `flags_out`=0x2, `out_valid` after E1. Repeat with rot=0, flags=0x2: `op2`=0x000000FF, `flags_out`=0x2.
- Register LSR #0, Rm=0x80000000: byimm=32 seen in EXEC, `op2`=0, C=1, `out_valid` after E2. Repeat with ROR #0, flags C=1, Rm=0x00000002: `op2`=0x80000001, C=0.
- Register LSL by Rs, Rs=0x100 (byte 0), Rm=0x80000001, flags=0x2: `op2`=0x80000001, `flags_out`=0x2, `rf_addr` sequence Rm then Rs, `out_valid` after E3.
- ROR by Rs=32, Rm=0x80000001: `op2`=0x80000001, C=1. Repeat with Rs=4 and Rm=0x0000001F: `op2`=0xF0000001, C=1.
- Hold `out_ready`=0 for 5 cycles in DONE: `op2`, `flags_out` and `out_valid` stay stable and `req_ready`=0. Then assert `rst_n`=0 mid-RD_RS: all outputs return to reset values immediately.
- With the macro defined, LSL by Rs=33, Rm=1, flags C=1: `op2`=0, C=0; with Rs=32: C=1. ASR by Rs=40, Rm=0x80000000: `op2`=0xFFFFFFFF, C=1.
